// File: rtl/temp_reg_pkg.sv
// Shared command encodings for the temp register bank.
package temp_reg_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOP   = 3'd0;
    localparam logic [OP_W-1:0] OP_LOAD  = 3'd1;
    localparam logic [OP_W-1:0] OP_INC   = 3'd2;
    localparam logic [OP_W-1:0] OP_DEC   = 3'd3;
    localparam logic [OP_W-1:0] OP_ADD   = 3'd4;
    localparam logic [OP_W-1:0] OP_CLEAR = 3'd5;

endpackage

// File: rtl/temp_reg_channel.sv
// One signed up/down register with registered sign/zero flags, sticky
// overflow and a one-cycle pulse when arithmetic brings a nonzero value to 0.
module temp_reg_channel
    import temp_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [OP_W-1:0]         op,
    input  logic signed [WIDTH-1:0] data,
    input  logic                    saturate,
    output logic [WIDTH-1:0]        value,
    output logic                    negative,
    output logic                    positive,
    output logic                    zero,
    output logic                    overflow,
    output logic                    zero_hit
);

    localparam logic [WIDTH-1:0] VAL_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] VAL_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] value_q, value_d;
    logic             negative_q, negative_d;
    logic             positive_q, positive_d;
    logic             zero_q, zero_d;
    logic             overflow_q, overflow_d;
    logic             zero_hit_q, zero_hit_d;

    logic [WIDTH:0]   operand;
    logic [WIDTH:0]   sum;
    logic             sum_in_range;
    logic             is_arith;

    // Next value, overflow and event; flags derive from the next value so
    // they never lag the stored register.
    always_comb begin
        operand      = '0;
        is_arith     = 1'b0;
        value_d      = value_q;
        overflow_d   = overflow_q;
        zero_hit_d   = 1'b0;

        case (op)
            OP_INC: begin
                operand  = {{WIDTH{1'b0}}, 1'b1};
                is_arith = 1'b1;
            end
            OP_DEC: begin
                operand  = '1;
                is_arith = 1'b1;
            end
            OP_ADD: begin
                operand  = {data[WIDTH-1], data};
                is_arith = 1'b1;
            end
            default: begin
                operand  = '0;
                is_arith = 1'b0;
            end
        endcase

        // Exact sum at WIDTH+1 bits; it fits in WIDTH bits when the top two bits agree.
        sum          = {value_q[WIDTH-1], value_q} + operand;
        sum_in_range = (sum[WIDTH] == sum[WIDTH-1]);

        if (en) begin
            if (op == OP_LOAD) begin
                value_d    = data;
                overflow_d = 1'b0;
            end else if (op == OP_CLEAR) begin
                value_d    = '0;
                overflow_d = 1'b0;
            end else if (is_arith) begin
                if (sum_in_range) begin
                    value_d = sum[WIDTH-1:0];
                end else begin
                    overflow_d = 1'b1;
                    if (saturate) begin
                        value_d = sum[WIDTH] ? VAL_MIN : VAL_MAX;
                    end else begin
                        value_d = sum[WIDTH-1:0];
                    end
                end
                // Saturation never yields 0, so only a true arithmetic landing counts.
                zero_hit_d = (value_q != '0) && (value_d == '0);
            end
        end

        negative_d = value_d[WIDTH-1];
        zero_d     = (value_d == '0);
        positive_d = !negative_d && !zero_d;
    end

    // State and flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_q    <= '0;
            negative_q <= 1'b0;
            positive_q <= 1'b0;
            zero_q     <= 1'b1;
            overflow_q <= 1'b0;
            zero_hit_q <= 1'b0;
        end else begin
            value_q    <= value_d;
            negative_q <= negative_d;
            positive_q <= positive_d;
            zero_q     <= zero_d;
            overflow_q <= overflow_d;
            zero_hit_q <= zero_hit_d;
        end
    end

    assign value    = value_q;
    assign negative = negative_q;
    assign positive = positive_q;
    assign zero     = zero_q;
    assign overflow = overflow_q;
    assign zero_hit = zero_hit_q;

endmodule

// File: rtl/temp_register_bank.sv
// Bank of independent signed registers: one command per cycle to the channel
// chosen by sel, plus a registered read port returning the pre-update value.
module temp_register_bank
    import temp_reg_pkg::*;
#(
    parameter int  WIDTH    = 8,
    parameter int  CHANNELS = 4,
    localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [OP_W-1:0]         op,
    input  logic [SEL_W-1:0]        sel,
    input  logic signed [WIDTH-1:0] data,
    input  logic                    saturate,
    input  logic [SEL_W-1:0]        rd_sel,
    output logic [WIDTH-1:0]        rd_data,
    output logic [CHANNELS-1:0]     negative,
    output logic [CHANNELS-1:0]     positive,
    output logic [CHANNELS-1:0]     zero,
    output logic [CHANNELS-1:0]     overflow,
    output logic [CHANNELS-1:0]     zero_hit
);

    logic [WIDTH-1:0] chan_value [CHANNELS];
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    // One channel per index; a sel beyond the last channel enables none of them.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic en;
            assign en = (sel == SEL_W'(gi));

            temp_reg_channel #(
                .WIDTH (WIDTH)
            ) u_chan (
                .clk      (clk),
                .reset    (reset),
                .en       (en),
                .op       (op),
                .data     (data),
                .saturate (saturate),
                .value    (chan_value[gi]),
                .negative (negative[gi]),
                .positive (positive[gi]),
                .zero     (zero[gi]),
                .overflow (overflow[gi]),
                .zero_hit (zero_hit[gi])
            );
        end
    endgenerate

    // Read mux; an out-of-range rd_sel reads as 0.
    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_data_d = chan_value[i];
            end
        end
    end

    // Read register samples stored values, so same-cycle writes show next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_temp_register_bank.sv
// Directed bench: a 4-channel bank for the main scenarios and a 3-channel
// bank sharing the same inputs for out-of-range select behaviour.
module tb_temp_register_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] op;
    logic [1:0] sel;
    logic [7:0] data;
    logic       saturate;
    logic [1:0] rd_sel;

    logic [7:0] rd_data4;
    logic [3:0] negative4, positive4, zero4, overflow4, zero_hit4;
    logic [7:0] rd_data3;
    logic [2:0] negative3, positive3, zero3, overflow3, zero_hit3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    temp_register_bank #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk(clk), .reset(reset), .op(op), .sel(sel), .data(data),
        .saturate(saturate), .rd_sel(rd_sel), .rd_data(rd_data4),
        .negative(negative4), .positive(positive4), .zero(zero4),
        .overflow(overflow4), .zero_hit(zero_hit4)
    );

    temp_register_bank #(.WIDTH(8), .CHANNELS(3)) dut3 (
        .clk(clk), .reset(reset), .op(op), .sel(sel), .data(data),
        .saturate(saturate), .rd_sel(rd_sel), .rd_data(rd_data3),
        .negative(negative3), .positive(positive3), .zero(zero3),
        .overflow(overflow3), .zero_hit(zero_hit3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] o, input logic [1:0] s, input logic [7:0] d);
        op   = o;
        sel  = s;
        data = d;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; op = 3'd2; sel = 2'd0; data = 8'h00; saturate = 1'b0; rd_sel = 2'd0;
        step();
        step();
        checks++;
        if (zero4 !== 4'b1111) begin errors++; $display("FAIL reset_zero got %b want %b", zero4, 4'b1111); end
        checks++;
        if ({negative4, positive4, overflow4, zero_hit4} !== 16'h0) begin
            errors++; $display("FAIL reset_flags got %h want 0000", {negative4, positive4, overflow4, zero_hit4});
        end
        checks++;
        if (rd_data4 !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h want 00", rd_data4); end
        reset = 1'b0;
        op    = 3'd0;
        for (int c = 0; c < 4; c++) begin
            rd_sel = 2'(c);
            step();
            checks++;
            if (rd_data4 !== 8'h00) begin errors++; $display("FAIL reset_value ch%0d got %h want 00", c, rd_data4); end
        end
        $display("test_reset done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_countdown();
        logic [7:0] exp_rd [4];
        int hits;
        exp_rd[0] = 8'hFD; exp_rd[1] = 8'hFE; exp_rd[2] = 8'hFF; exp_rd[3] = 8'h00;
        hits = 0;
        saturate = 1'b0;
        rd_sel   = 2'd1;
        drive(3'd1, 2'd1, 8'hFD);
        checks++;
        if (negative4[1] !== 1'b1) begin errors++; $display("FAIL countdown_neg_load got %b want 1", negative4[1]); end
        for (int k = 0; k < 4; k++) begin
            drive((k < 3) ? 3'd2 : 3'd0, 2'd1, 8'h00);
            hits += int'(zero_hit4[1]);
            checks++;
            if (rd_data4 !== exp_rd[k]) begin errors++; $display("FAIL countdown_rd k=%0d got %h want %h", k, rd_data4, exp_rd[k]); end
            checks++;
            if (zero_hit4[1] !== (k == 2)) begin errors++; $display("FAIL countdown_hit k=%0d got %b want %b", k, zero_hit4[1], k == 2); end
            if (k == 2) begin
                checks++;
                if ({negative4[1], zero4[1], positive4[1]} !== 3'b010) begin
                    errors++; $display("FAIL countdown_flags got %b want 010", {negative4[1], zero4[1], positive4[1]});
                end
            end
        end
        checks++;
        if (hits != 1) begin errors++; $display("FAIL countdown_hit_count got %0d want 1", hits); end
        $display("test_countdown done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_saturate();
        saturate = 1'b1;
        rd_sel   = 2'd2;
        drive(3'd1, 2'd2, 8'd126);
        drive(3'd2, 2'd2, 8'h00);
        checks++;
        if (overflow4[2] !== 1'b0) begin errors++; $display("FAIL sat_ovf_first got %b want 0", overflow4[2]); end
        drive(3'd2, 2'd2, 8'h00);
        checks++;
        if (overflow4[2] !== 1'b1) begin errors++; $display("FAIL sat_ovf_second got %b want 1", overflow4[2]); end
        checks++;
        if (rd_data4 !== 8'd127) begin errors++; $display("FAIL sat_rd_first got %h want 7f", rd_data4); end
        drive(3'd2, 2'd2, 8'h00);
        checks++;
        if (rd_data4 !== 8'd127 || positive4[2] !== 1'b1) begin
            errors++; $display("FAIL sat_rd_second got %h/%b want 7f/1", rd_data4, positive4[2]);
        end
        drive(3'd1, 2'd2, 8'd5);
        checks++;
        if (rd_data4 !== 8'd127) begin errors++; $display("FAIL sat_rd_third got %h want 7f", rd_data4); end
        checks++;
        if (overflow4[2] !== 1'b0) begin errors++; $display("FAIL sat_ovf_load got %b want 0", overflow4[2]); end
        drive(3'd0, 2'd2, 8'h00);
        checks++;
        if (rd_data4 !== 8'd5) begin errors++; $display("FAIL sat_rd_load got %h want 05", rd_data4); end
        $display("test_saturate done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_wrap();
        saturate = 1'b0;
        rd_sel   = 2'd0;
        drive(3'd1, 2'd0, 8'd127);
        drive(3'd2, 2'd0, 8'h00);
        checks++;
        if ({negative4[0], overflow4[0], zero_hit4[0]} !== 3'b110) begin
            errors++; $display("FAIL wrap_inc got n/o/h=%b want 110", {negative4[0], overflow4[0], zero_hit4[0]});
        end
        drive(3'd4, 2'd0, 8'h80);
        checks++;
        if (rd_data4 !== 8'h80) begin errors++; $display("FAIL wrap_rd got %h want 80", rd_data4); end
        checks++;
        if ({zero4[0], zero_hit4[0], overflow4[0]} !== 3'b111) begin
            errors++; $display("FAIL wrap_add_zero got z/h/o=%b want 111", {zero4[0], zero_hit4[0], overflow4[0]});
        end
        drive(3'd4, 2'd0, 8'h00);
        checks++;
        if (zero_hit4[0] !== 1'b0 || zero4[0] !== 1'b1) begin
            errors++; $display("FAIL wrap_add0 got h/z=%b%b want 01", zero_hit4[0], zero4[0]);
        end
        drive(3'd5, 2'd0, 8'h00);
        checks++;
        if (overflow4[0] !== 1'b0 || zero_hit4[0] !== 1'b0) begin
            errors++; $display("FAIL wrap_clear got o/h=%b%b want 00", overflow4[0], zero_hit4[0]);
        end
        $display("test_wrap done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_read_invalid();
        // 3-channel bank holds ch0=0, ch1=0, ch2=5 from the previous scenarios.
        rd_sel = 2'd3;
        drive(3'd1, 2'd3, 8'd9);
        checks++;
        if ({zero3, positive3, negative3, overflow3, zero_hit3} !== 15'b011_100_000_000_000) begin
            errors++; $display("FAIL invalid_sel_flags got %b want 011100000000000",
                               {zero3, positive3, negative3, overflow3, zero_hit3});
        end
        checks++;
        if (positive4[3] !== 1'b1) begin errors++; $display("FAIL ch3_load4 got %b want 1", positive4[3]); end
        drive(3'd0, 2'd0, 8'h00);
        checks++;
        if (rd_data3 !== 8'h00) begin errors++; $display("FAIL invalid_rd got %h want 00", rd_data3); end
        checks++;
        if (rd_data4 !== 8'd9) begin errors++; $display("FAIL rd_ch3 got %h want 09", rd_data4); end
        rd_sel = 2'd1;
        drive(3'd1, 2'd1, 8'd7);
        checks++;
        if (rd_data4 !== 8'h00 || rd_data3 !== 8'h00) begin
            errors++; $display("FAIL rd_old got %h/%h want 00/00", rd_data4, rd_data3);
        end
        drive(3'd0, 2'd1, 8'h00);
        checks++;
        if (rd_data4 !== 8'd7 || rd_data3 !== 8'd7) begin
            errors++; $display("FAIL rd_new got %h/%h want 07/07", rd_data4, rd_data3);
        end
        $display("test_read_invalid done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_reset_midrun();
        saturate = 1'b0;
        rd_sel   = 2'd3;
        // ch3 starts at 9: 9 -> 10 -> 20 -> 21 -> 31
        drive(3'd2, 2'd3, 8'd0);
        drive(3'd4, 2'd3, 8'd10);
        drive(3'd2, 2'd3, 8'd0);
        drive(3'd4, 2'd3, 8'd10);
        checks++;
        if (rd_data4 !== 8'd21 || positive4[3] !== 1'b1) begin
            errors++; $display("FAIL midrun_count got %h/%b want 15/1", rd_data4, positive4[3]);
        end
        reset = 1'b1;
        drive(3'd4, 2'd3, 8'd10);
        reset = 1'b0;
        checks++;
        if (zero4 !== 4'b1111 || zero_hit4 !== 4'b0000 || positive4 !== 4'b0000) begin
            errors++; $display("FAIL midrun_flags got z=%b h=%b p=%b want 1111/0000/0000", zero4, zero_hit4, positive4);
        end
        checks++;
        if (zero3 !== 3'b111) begin errors++; $display("FAIL midrun_zero3 got %b want 111", zero3); end
        drive(3'd0, 2'd3, 8'h00);
        checks++;
        if (rd_data4 !== 8'h00) begin errors++; $display("FAIL midrun_rd got %h want 00", rd_data4); end
        $display("test_reset_midrun done checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_saturate();
        test_wrap();
        test_read_invalid();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/temp_register_bank.md
Name: temp_register_bank

Overview:
- Bank of CHANNELS independent signed WIDTH-bit up/down registers for stepper position, step-count and delay bookkeeping in the ASIP datapath.
- Each cycle, one command is applied to one selected channel.
- Sign/zero flags are registered and reflect the post-update value in the same cycle as the register update, with no one-cycle flag lag.
- Adds saturate/wrap arithmetic, signed add, sticky overflow, zero-reached event pulses and a registered read port.

Parameters:
- WIDTH, 8, data width of each channel register (two's complement, WIDTH >= 2).
- CHANNELS, 4, number of channels (1..16).
- SEL_W, max(1, clog2(CHANNELS)), derived localparam; width of channel selects.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- op  in  3  command: 0 NOP, 1 LOAD, 2 INC, 3 DEC, 4 ADD, 5 CLEAR, 6/7 treated as NOP.
- sel  in  SEL_W  target channel for op.
- data  in  WIDTH  signed operand for LOAD/ADD.
- saturate  in  1  1 = clamp at limits, 0 = two's-complement wrap; sampled with op.
- rd_sel  in  SEL_W  read channel select.
- rd_data  out  WIDTH  registered value of channel rd_sel.
- negative  out  CHANNELS  per-channel value < 0.
- positive  out  CHANNELS  per-channel value > 0.
- zero  out  CHANNELS  per-channel value == 0.
- overflow  out  CHANNELS  sticky per-channel overflow/saturation.
- zero_hit  out  CHANNELS  one-cycle pulse: channel became zero through arithmetic.

Behaviour:
- Reset (synchronous, highest priority): all channel values 0; zero all 1s; negative, positive, overflow, zero_hit all 0; rd_data 0.
- Reset asserted mid-operation overrides any op in that cycle.
- Limits: MAX = 2^(WIDTH-1)-1, MIN = -2^(WIDTH-1).
- Per-op effect on the selected channel, taking effect at the next clk edge:
  - LOAD: value <= data; overflow <= 0.
  - CLEAR: value <= 0; overflow <= 0.
  - INC / DEC / ADD: exact sum computed at WIDTH+1 bits (value+1, value-1, value+data).
    - Sum in range: value <= sum; overflow unchanged.
    - Sum out of range, saturate=1: value <= MAX or MIN (by sum sign); overflow <= 1.
    - Sum out of range, saturate=0: value <= low WIDTH bits of sum; overflow <= 1.
  - NOP / reserved op: no change.
- sel >= CHANNELS: op ignored entirely; no flag or pulse changes.
- Unselected channels hold their value and overflow.
- Flags are registered from the next value, so after the edge they always match the stored value. Exactly one of negative/zero/positive is 1 per channel at all times.
- zero_hit[i] = 1 for exactly the cycle after an INC/DEC/ADD on channel i that moves a nonzero value to 0. This includes a wrap to 0, e.g. WIDTH=8, 255 interpreted as -1, INC gives 0.
- zero_hit[i] = 0 in all other cycles: after LOAD 0, CLEAR, ADD 0 on a zero value, or a zero value saturating.
- rd_data <= value[rd_sel] sampled at the edge, i.e. the pre-update value; 1-cycle latency.
  - Reading the channel being written in the same cycle returns the old value; the new value is visible one cycle later.
  - rd_sel >= CHANNELS returns 0.
- No multi-cycle state machine: each channel is a registered update datapath with a per-channel event detector.

Decomposition:
- Package temp_reg_pkg: op encodings (OP_NOP, OP_LOAD, OP_INC, OP_DEC, OP_ADD, OP_CLEAR) and the 3-bit op width constant.
- Sub-module temp_reg_channel:
  - Contains one value register, the flag registers, sticky overflow and the zero_hit pulse.
  - Inputs: clk, reset, en (sel match), op, data, saturate.
  - Exposes value and flags.
  - Instantiated CHANNELS times by a generate loop.
- Top level holds sel decode and the read mux/register.

Test Plan:
- Reset: assert reset for 2 cycles with op=INC, sel=0 driven -> all values 0, zero=4'b1111, rd_data=0, no zero_hit.
- Countdown: LOAD ch1 = -3, then INC x3 -> ch1 reads -2, -1, 0; negative[1] clears with the third INC; zero_hit[1] pulses exactly once; zero[1]=1.
- Saturate: LOAD ch2 = 126, saturate=1, INC x3 -> 127, 127, 127; overflow[2]=1 after the second INC. LOAD 5 -> overflow[2]=0.
- Wrap: saturate=0, LOAD ch0 = 127, INC -> -128, negative[0]=1, overflow[0]=1. ADD -128 to -128 -> 0, zero_hit[0] pulses.
- Read/invalid sel: CHANNELS=3, op=LOAD sel=3 data=9 -> no channel changes. rd_sel=3 -> rd_data=0. Write ch1 while rd_sel=1 -> old value, new value next cycle.
- Reset mid-run: ch3 counting with alternating INC/ADD 10, assert reset one cycle -> ch3=0 and zero[3]=1 next cycle, zero_hit[3]=0, other channels 0.
